tap_sequencer: RTL and testbench
================================

TAP_SEQUENCER -- requirements
Module: tap_sequencer

Interface
REQ-001 SHALL have parameter TAPS, default 64, filter length and number of phases per sample.
REQ-002 SHALL have parameter DATA_W, default 16, sample width (signed integer).
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have port clk_enable  in  1  global advance enable; 0 freezes all state.
REQ-006 SHALL have port in_sample  in  DATA_W  new audio sample x(n), signed.
REQ-007 SHALL have port in_valid  in  1  in_sample valid.
REQ-008 SHALL have port in_ready  out  1  block accepts a sample this cycle.
REQ-009 SHALL have port flush  in  1  request to zero the sample history.
REQ-010 SHALL have port input_mux  out  DATA_W  x(n-k) for current phase k, to MAC stage.
REQ-011 SHALL have port tap_index  out  6  current phase k, to coefficient lookup.
REQ-012 SHALL have port phase_0  out  1  high during phase k=0.
REQ-013 SHALL have port phase_63  out  1  high during phase k=TAPS-1.
REQ-014 SHALL have port mac_active  out  1  high while in RUN.
REQ-015 SHALL have port frame_done  out  1  one-cycle pulse after final phase of a frame.

Function
REQ-016 SHALL hold a TAPS x DATA_W circular history buffer and 6-bit write pointer wr_ptr.
REQ-017 SHALL implement FSM states IDLE, RUN, CLEAR; reset state IDLE.
REQ-018 SHALL accept a sample on a rising edge where in_valid=1, in_ready=1, clk_enable=1: write buffer[wr_ptr], wr_ptr+1 mod TAPS, enter RUN with k=0.
REQ-019 SHALL drive in_ready=1 only when clk_enable=1, no flush pending, and (state IDLE, or state RUN with k=TAPS-1).
REQ-020 SHALL present phase k=0 the cycle after acceptance (latency 1); input_mux = just-written sample.
REQ-021 SHALL, in RUN, drive input_mux = buffer[(newest_ptr - k) mod TAPS], tap_index = k, all outputs registered and mutually aligned.
REQ-022 SHALL increment k by 1 per enabled cycle, k=0..TAPS-1, wrap-around of address mod TAPS exact.
REQ-023 SHALL, after k=TAPS-1 with no acceptance, return to IDLE and pulse frame_done for one cycle.
REQ-024 SHALL, on acceptance during k=TAPS-1 (back-to-back), go directly to k=0 of the new frame, still pulsing frame_done; throughput one sample per TAPS cycles.
REQ-025 SHALL, with clk_enable=0, hold state, k, buffer, wr_ptr and all outputs; frame_done SHALL not repeat.
REQ-026 SHALL drive phase_0, phase_63, mac_active low and input_mux, tap_index to 0 outside RUN.
REQ-027 SHALL latch flush asserted in any state as pending; serviced only from IDLE.
REQ-028 SHALL, when pending flush and in_valid coincide in IDLE, give flush priority (enter CLEAR, no acceptance).
REQ-029 SHALL, in CLEAR, zero one buffer entry per enabled cycle over TAPS cycles, in_ready=0, then reset wr_ptr to 0, clear pending, return to IDLE.
REQ-030 SHALL not modify sample data arithmetically; buffer content is bit-exact in_sample.

Reset
REQ-031 SHALL, while rst=0, asynchronously force state IDLE, k=0, wr_ptr=0, buffer all zero, flush pending 0, all outputs 0.
REQ-032 SHALL, on reset mid-RUN or mid-CLEAR, abort immediately; first acceptance after release starts k=0 with otherwise-zero history.

Verification
REQ-033 SHALL check: after reset, accept 0x0123 -> next cycle phase_0=1, tap_index=0, input_mux=0x0123; phases 1..63 input_mux=0; phase_63 at cycle 64; frame_done at cycle 65.
REQ-034 SHALL check: 65 consecutive samples 1..65 back-to-back -> frame for sample 65 shows input_mux = 65,64,...,2 (wrap-around, oldest dropped), no idle cycle between frames.
REQ-035 SHALL check: clk_enable=0 for 10 cycles at k=20 -> tap_index stays 20, input_mux unchanged, in_ready=0, frame completes 10 cycles later.
REQ-036 SHALL check: flush pulsed at k=30 with in_valid=1 held -> frame finishes, CLEAR for 64 cycles with in_ready=0, next accepted 0x7FFF frame shows 0x7FFF then 63 zeros.
REQ-037 SHALL check: rst=0 asserted at k=40 -> outputs 0 immediately; after release and sample 0x8000 accepted -> input_mux 0x8000 then 63 zeros.

Source files
------------

// File: rtl/tap_sequencer.sv
// Tap sequencer: keeps a circular history of input samples and, for each accepted
// sample, walks the FIR phases k=0..TAPS-1 presenting x(n-k) and k to the MAC stage.
module tap_sequencer #(
    parameter int TAPS   = 64,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_enable,
    input  logic [DATA_W-1:0] in_sample,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [DATA_W-1:0] input_mux,
    output logic [5:0]        tap_index,
    output logic              phase_0,
    output logic              phase_63,
    output logic              mac_active,
    output logic              frame_done
);

    // state | meaning
    // IDLE  | waiting for a sample or a pending flush
    // RUN   | presenting phase k of the current frame
    // CLEAR | zeroing one history entry per enabled cycle
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam logic [5:0] K_LAST = 6'(TAPS - 1);
    localparam logic [6:0] TAPS_7 = 7'(TAPS);

    state_t            state;
    logic [5:0]        k;
    logic [5:0]        wr_ptr;
    logic [5:0]        newest_ptr;
    logic [5:0]        clr_cnt;
    logic              flush_pend;
    logic [DATA_W-1:0] hist [TAPS];

    logic              flush_req;
    logic              last_phase;
    logic              accept;
    logic [5:0]        k_next;
    logic [5:0]        rd_addr;
    logic [5:0]        wr_ptr_next;

    always_comb begin
        flush_req   = flush_pend | flush;
        last_phase  = (state == RUN) && (k == K_LAST);
        // rst gates in_ready so every output reads 0 while reset is held
        in_ready    = rst && clk_enable && !flush_req && ((state == IDLE) || last_phase);
        accept      = in_ready && in_valid;
        k_next      = k + 6'd1;
        wr_ptr_next = (wr_ptr == K_LAST) ? 6'd0 : wr_ptr + 6'd1;
        if (newest_ptr >= k_next) begin
            rd_addr = newest_ptr - k_next;
        end else begin
            rd_addr = 6'(TAPS_7 + {1'b0, newest_ptr} - {1'b0, k_next});
        end
    end

    assign tap_index = k;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            k          <= '0;
            wr_ptr     <= '0;
            newest_ptr <= '0;
            clr_cnt    <= '0;
            flush_pend <= 1'b0;
            input_mux  <= '0;
            phase_0    <= 1'b0;
            phase_63   <= 1'b0;
            mac_active <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                hist[i] <= '0;
            end
        end else if (!clk_enable) begin
            // frozen: everything holds, but a completed frame is only reported once
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            flush_pend <= flush_pend | flush;
            if (accept) begin
                hist[wr_ptr] <= in_sample;
                newest_ptr   <= wr_ptr;
                wr_ptr       <= wr_ptr_next;
                state        <= RUN;
                k            <= '0;
                input_mux    <= in_sample;
                phase_0      <= 1'b1;
                phase_63     <= (K_LAST == 6'd0);
                mac_active   <= 1'b1;
                frame_done   <= last_phase;
            end else begin
                case (state)
                    IDLE: begin
                        if (flush_req) begin
                            state      <= CLEAR;
                            clr_cnt    <= K_LAST;
                            flush_pend <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (last_phase) begin
                            state      <= IDLE;
                            k          <= '0;
                            input_mux  <= '0;
                            phase_0    <= 1'b0;
                            phase_63   <= 1'b0;
                            mac_active <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            k         <= k_next;
                            input_mux <= hist[rd_addr];
                            phase_0   <= 1'b0;
                            phase_63  <= (k_next == K_LAST);
                        end
                    end
                    CLEAR: begin
                        hist[clr_cnt] <= '0;
                        if (clr_cnt == 6'd0) begin
                            state      <= IDLE;
                            wr_ptr     <= '0;
                            flush_pend <= 1'b0;
                        end else begin
                            clr_cnt <= clr_cnt - 6'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tap_sequencer.sv
// Scoreboard bench for tap_sequencer: a queue-based history model predicts every
// presented phase and frame_done; a negedge monitor pops and compares.
module tb_tap_sequencer;

    localparam int TAPS = 64;
    localparam int DW   = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clk_enable = 1'b1;
    logic [DW-1:0] in_sample = '0;
    logic          in_valid = 1'b0;
    logic          flush = 1'b0;
    logic          in_ready;
    logic [DW-1:0] input_mux;
    logic [5:0]    tap_index;
    logic          phase_0;
    logic          phase_63;
    logic          mac_active;
    logic          frame_done;

    tap_sequencer #(.TAPS(TAPS), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_enable (clk_enable),
        .in_sample  (in_sample),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .input_mux  (input_mux),
        .tap_index  (tap_index),
        .phase_0    (phase_0),
        .phase_63   (phase_63),
        .mac_active (mac_active),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_done;
        int            k;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] mhist[$];
    bit            m_pend = 1'b0;
    int            m_clear = 0;
    int            n_checks = 0;
    int            n_errors = 0;

    logic [DW-1:0] last_mux;
    logic [5:0]    last_k;
    logic          last_p0, last_p63, last_act;
    bit            have_last = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sbq.delete();
        mhist.delete();
        m_pend  = 1'b0;
        m_clear = 0;
    endtask

    // One clock of stimulus: drive after the monitor's negedge, then predict the next posedge.
    task automatic step(input bit en, input bit v, input logic [DW-1:0] s, input bit fl);
        bit exp_ready;
        @(negedge clk);
        #1;
        clk_enable = en;
        in_valid   = v;
        in_sample  = s;
        flush      = fl;
        #1;
        exp_ready = en && !m_pend && !fl && (m_clear == 0) &&
                    ((sbq.size() == 0) || (sbq.size() == 1 && sbq[0].is_done));
        chk("in_ready", int'(in_ready), int'(exp_ready));
        if (en) begin
            if (m_clear > 0) begin
                m_clear--;
                if (m_clear == 0) begin
                    mhist.delete();
                    m_pend = 1'b0;
                end
            end else if (exp_ready && v) begin
                exp_t e;
                mhist.push_front(s);
                if (mhist.size() > TAPS) void'(mhist.pop_back());
                for (int k = 0; k < TAPS; k++) begin
                    e.is_done = 1'b0;
                    e.k       = k;
                    e.data    = (k < mhist.size()) ? mhist[k] : '0;
                    sbq.push_back(e);
                end
                e.is_done = 1'b1;
                e.k       = 0;
                e.data    = '0;
                sbq.push_back(e);
            end else begin
                if (fl) m_pend = 1'b1;
                if (sbq.size() == 0 && m_pend) m_clear = TAPS;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            have_last = 1'b0;
        end else begin
            if (clk_enable) begin
                bit exp_done, exp_act;
                exp_done = (sbq.size() > 0) && sbq[0].is_done;
                chk("frame_done", int'(frame_done), int'(exp_done));
                if (exp_done) void'(sbq.pop_front());
                exp_act = (sbq.size() > 0) && !sbq[0].is_done;
                chk("mac_active", int'(mac_active), int'(exp_act));
                if (exp_act) begin
                    if (mac_active) begin
                        chk("tap_index", int'(tap_index), sbq[0].k);
                        chk("input_mux", int'(input_mux), int'(sbq[0].data));
                        chk("phase_0", int'(phase_0), int'(sbq[0].k == 0));
                        chk("phase_63", int'(phase_63), int'(sbq[0].k == TAPS - 1));
                    end
                    void'(sbq.pop_front());
                end else if (!mac_active) begin
                    chk("idle_input_mux", int'(input_mux), 0);
                    chk("idle_tap_index", int'(tap_index), 0);
                    chk("idle_phase_0", int'(phase_0), 0);
                    chk("idle_phase_63", int'(phase_63), 0);
                end
            end else begin
                chk("frozen_frame_done", int'(frame_done), 0);
                if (have_last) begin
                    chk("hold_input_mux", int'(input_mux), int'(last_mux));
                    chk("hold_tap_index", int'(tap_index), int'(last_k));
                    chk("hold_phase_0", int'(phase_0), int'(last_p0));
                    chk("hold_phase_63", int'(phase_63), int'(last_p63));
                    chk("hold_mac_active", int'(mac_active), int'(last_act));
                end
            end
            last_mux  = input_mux;
            last_k    = tap_index;
            last_p0   = phase_0;
            last_p63  = phase_63;
            last_act  = mac_active;
            have_last = 1'b1;
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_input_mux"}, int'(input_mux), 0);
        chk({tag, "_tap_index"}, int'(tap_index), 0);
        chk({tag, "_phase_0"}, int'(phase_0), 0);
        chk({tag, "_phase_63"}, int'(phase_63), 0);
        chk({tag, "_mac_active"}, int'(mac_active), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] s;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        #1 rst = 1'b1;

        // single sample into empty history
        step(1'b1, 1'b1, 16'h0123, 1'b0);
        drain(70);

        // 65 back-to-back samples, history wraps
        s = 16'd1;
        while (s <= 16'd65) begin
            bit was_ready;
            step(1'b1, 1'b1, s, 1'b0);
            was_ready = (sbq.size() == TAPS + 1) || (sbq.size() == TAPS + 2);
            if (was_ready && sbq[sbq.size() - 2].data == 16'(0) && s == 16'd1) s = s + 16'd1;
            else if (was_ready && sbq[sbq.size() - TAPS - 1].data == s) s = s + 16'd1;
        end
        drain(70);

        // freeze for 10 cycles while showing k=20
        step(1'b1, 1'b1, 16'h0A0A, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 16'h0B0B, 1'b0);
            chk("freeze_tap_index", int'(tap_index), 20);
        end
        drain(70);

        // flush at k=30 with in_valid held throughout
        step(1'b1, 1'b1, 16'h1111, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 16'h1111, 1'b0);
        step(1'b1, 1'b1, 16'h7FFF, 1'b1);
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 16'h7FFF, 1'b0);
        drain(70);

        // asynchronous reset while showing k=40
        step(1'b1, 1'b1, 16'h5555, 1'b0);
        for (int i = 0; i < 41; i++) step(1'b1, 1'b0, '0, 1'b0);
        chk("pre_reset_tap_index", int'(tap_index), 40);
        rst = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        model_reset();
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        step(1'b1, 1'b1, 16'h8000, 1'b0);
        drain(70);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                 16'($urandom), ($urandom_range(0, 49) == 0));
        end
        drain(200);

        chk("scoreboard_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
